axi4_hash_block_master: RTL

AXI4-Lite master that feeds one hash block into the hash core's AXI4-Lite slave register interface and tracks the result. On a `start_i` pulse it does four things in order:
- captures `block_i`;
- writes the block as `NumRegs` data-register writes;
- writes the enable bit of the control register;
- polls the control register until the hash core has consumed the enable.

It sits between the local controller (message padding/scheduling logic) and the register slave, and reports completion, bus errors and poll timeouts.

---
 rtl/axi4_hash_block_master.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/axi4_hash_block_master.sv
// AXI4-Lite master that pushes one hash block into the hash core's register
// slave, sets the control enable bit, then polls until the core clears it.
module axi4_hash_block_master #(
  parameter int unsigned          DataWidth  = 32,
  parameter int unsigned          AddrWidth  = 32,
  parameter int unsigned          BlockWidth = 512,
  parameter bit                   ByteAlign  = 1'b1,
  parameter logic [AddrWidth-1:0] BaseAddr   = '0,
  parameter int unsigned          PollLimit  = 1024
) (
  input  logic                    aclk_i,
  input  logic                    areset_ni,
  output logic                    awvalid_m_o,
  input  logic                    awready_m_i,
  output logic [AddrWidth-1:0]    awaddr_m_o,
  output logic [2:0]              awprot_m_o,
  output logic                    wvalid_m_o,
  input  logic                    wready_m_i,
  output logic [DataWidth-1:0]    wdata_m_o,
  output logic [DataWidth/8-1:0]  wstrb_m_o,
  input  logic                    bvalid_m_i,
  output logic                    bready_m_o,
  input  logic [1:0]              bresp_m_i,
  output logic                    arvalid_m_o,
  input  logic                    arready_m_i,
  output logic [AddrWidth-1:0]    araddr_m_o,
  output logic [2:0]              arprot_m_o,
  input  logic                    rvalid_m_i,
  output logic                    rready_m_o,
  input  logic [DataWidth-1:0]    rdata_m_i,
  input  logic [1:0]              rresp_m_i,
  input  logic                    start_i,
  input  logic [BlockWidth-1:0]   block_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [1:0]              status_o
);

  localparam int unsigned NumRegs  = BlockWidth / DataWidth;
  localparam int unsigned AddrStep = DataWidth / (ByteAlign ? 8 : 32);
  localparam int unsigned AddrBits = $clog2(NumRegs * AddrStep);
  localparam logic [AddrWidth-1:0] CtrlAddr = BaseAddr + (AddrWidth'(1) << AddrBits);
  localparam int unsigned CntW     = $clog2(NumRegs + 1);
  localparam int unsigned PollW    = $clog2(PollLimit + 1);

  typedef enum logic [2:0] {StIdle, StWrite, StWresp, StRead, StRresp, StDone} state_e;

  state_e                r_state, w_state_d;
  logic [BlockWidth-1:0] r_block, w_block_d;
  logic [CntW-1:0]       r_wcnt, w_wcnt_d;
  logic [PollW-1:0]      r_pcnt, w_pcnt_d;
  logic [1:0]            r_status, w_status_d;
  logic                  r_aw_done, w_aw_done_d;
  logic                  r_w_done, w_w_done_d;
  logic [AddrWidth-1:0]  r_awaddr, w_awaddr_d;
  logic [DataWidth-1:0]  r_wdata, w_wdata_d;
  logic [AddrWidth-1:0]  r_araddr, w_araddr_d;

  // Address/data of the next write beat: word 0 from block_i at start, later words from r_block
  logic [CntW-1:0]       w_widx;
  logic [BlockWidth-1:0] w_src, w_shift;
  logic [AddrWidth-1:0]  w_waddr;
  logic [DataWidth-1:0]  w_wdata;

  // Select the next beat's address and data; index NumRegs is the control-register write
  always_comb begin
    w_widx  = (r_state == StIdle) ? '0 : r_wcnt + CntW'(1);
    w_src   = (r_state == StIdle) ? block_i : r_block;
    w_shift = w_src >> (32'(w_widx) * DataWidth);
    if (w_widx == CntW'(NumRegs)) begin
      w_waddr = CtrlAddr;
      w_wdata = DataWidth'(1);
    end else begin
      w_waddr = BaseAddr + AddrWidth'(32'(w_widx) * AddrStep);
      w_wdata = w_shift[DataWidth-1:0];
    end
  end

  // Next-state logic for the transfer sequencer
  always_comb begin
    w_state_d   = r_state;
    w_block_d   = r_block;
    w_wcnt_d    = r_wcnt;
    w_pcnt_d    = r_pcnt;
    w_status_d  = r_status;
    w_aw_done_d = r_aw_done;
    w_w_done_d  = r_w_done;
    w_awaddr_d  = r_awaddr;
    w_wdata_d   = r_wdata;
    w_araddr_d  = r_araddr;
    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          w_block_d   = block_i;
          w_wcnt_d    = '0;
          w_pcnt_d    = '0;
          w_status_d  = 2'd0;
          w_aw_done_d = 1'b0;
          w_w_done_d  = 1'b0;
          w_awaddr_d  = w_waddr;
          w_wdata_d   = w_wdata;
          w_state_d   = StWrite;
        end
      end
      StWrite: begin
        // AW and W complete independently; leave only once both have handshaken
        if (awvalid_m_o && awready_m_i) w_aw_done_d = 1'b1;
        if (wvalid_m_o && wready_m_i)   w_w_done_d  = 1'b1;
        if (w_aw_done_d && w_w_done_d)  w_state_d   = StWresp;
      end
      StWresp: begin
        if (bvalid_m_i) begin
          if (bresp_m_i[1]) begin
            w_status_d = 2'd1;
            w_state_d  = StDone;
          end else if (r_wcnt == CntW'(NumRegs)) begin
            w_araddr_d = CtrlAddr;
            w_state_d  = StRead;
          end else begin
            w_wcnt_d    = r_wcnt + CntW'(1);
            w_aw_done_d = 1'b0;
            w_w_done_d  = 1'b0;
            w_awaddr_d  = w_waddr;
            w_wdata_d   = w_wdata;
            w_state_d   = StWrite;
          end
        end
      end
      StRead: begin
        if (arready_m_i) w_state_d = StRresp;
      end
      StRresp: begin
        if (rvalid_m_i) begin
          if (rresp_m_i[1]) begin
            w_status_d = 2'd1;
            w_state_d  = StDone;
          end else if (!rdata_m_i[0]) begin
            w_status_d = 2'd0;
            w_state_d  = StDone;
          end else if (r_pcnt + PollW'(1) == PollW'(PollLimit)) begin
            w_status_d = 2'd2;
            w_state_d  = StDone;
          end else begin
            w_pcnt_d  = r_pcnt + PollW'(1);
            w_state_d = StRead;
          end
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge aclk_i or negedge areset_ni) begin
    if (!areset_ni) begin
      r_state   <= StIdle;
      r_block   <= '0;
      r_wcnt    <= '0;
      r_pcnt    <= '0;
      r_status  <= 2'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_araddr  <= '0;
    end else begin
      r_state   <= w_state_d;
      r_block   <= w_block_d;
      r_wcnt    <= w_wcnt_d;
      r_pcnt    <= w_pcnt_d;
      r_status  <= w_status_d;
      r_aw_done <= w_aw_done_d;
      r_w_done  <= w_w_done_d;
      r_awaddr  <= w_awaddr_d;
      r_wdata   <= w_wdata_d;
      r_araddr  <= w_araddr_d;
    end
  end

  // Handshake outputs decode registered state only, so no AXI input reaches an AXI output
  assign awvalid_m_o = (r_state == StWrite) && !r_aw_done;
  assign wvalid_m_o  = (r_state == StWrite) && !r_w_done;
  assign bready_m_o  = (r_state == StWresp);
  assign arvalid_m_o = (r_state == StRead);
  assign rready_m_o  = (r_state == StRresp);
  assign awaddr_m_o  = r_awaddr;
  assign wdata_m_o   = r_wdata;
  assign araddr_m_o  = r_araddr;
  assign wstrb_m_o   = '1;
  assign awprot_m_o  = 3'b000;
  assign arprot_m_o  = 3'b000;
  assign busy_o      = (r_state != StIdle);
  assign done_o      = (r_state == StDone);
  assign status_o    = r_status;

  // Only the enable bit and the error bit of each response matter
  logic w_unused;
  assign w_unused = ^{rdata_m_i[DataWidth-1:1], bresp_m_i[0], rresp_m_i[0]};

endmodule
